// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: state encoding, id width helper and counter width shared by the FIFO write arbiter
package fifo_arb_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    localparam int WCNT_W = 16;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting at ptr+1, wrapping modulo N
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] j;
    // Walk from the farthest offset down so the nearest candidate after ptr wins last
    always_comb begin
        onehot = '0;
        idx    = '0;
        j      = '0;
        for (int k = N; k >= 1; k--) begin
            j = ptr + IW'(k);
            if (req[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
                idx       = j;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-granular round-robin arbiter feeding a FIFO write port, with stall timeout
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DATASIZE = 8,
    parameter int IDLE_TO  = 15
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wfull,
    output logic                     winc,
    output logic [DATASIZE-1:0]      wdata,
    output logic [id_w(NREQ)-1:0]    gnt_id,
    output logic                     busy,
    output logic                     abort_err,
    output logic [WCNT_W-1:0]        wr_count
);
    localparam int IW = id_w(NREQ);
    localparam int TW = $clog2(IDLE_TO + 1);

    state_t               state, state_n;
    logic [IW-1:0]        rr_ptr, rr_ptr_n, gnt_n, pick_idx;
    logic [NREQ-1:0]      pick_oh;
    logic [TW-1:0]        stall_cnt, stall_n;
    logic                 abort_n;
    logic [DATASIZE-1:0]  sel_data, wdata_q;
    logic                 gnt_valid, gnt_last;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt_id == IW'(i)) sel_data = req_data[i*DATASIZE +: DATASIZE];
    end

    assign busy      = (state == BUSY);
    assign gnt_valid = req_valid[gnt_id];
    assign gnt_last  = req_last[gnt_id];
    assign winc      = busy && gnt_valid && !wfull;
    assign req_ready = (busy && !wfull) ? (NREQ'(1) << gnt_id) : '0;
    assign wdata     = busy ? sel_data : wdata_q;

    // wfull stalls freeze the counter; only an idle requester counts toward the timeout
    always_comb begin
        state_n  = state;
        gnt_n    = gnt_id;
        rr_ptr_n = rr_ptr;
        stall_n  = stall_cnt;
        abort_n  = abort_err;
        if (state == IDLE) begin
            stall_n = '0;
            if (|req_valid) begin
                state_n = BUSY;
                gnt_n   = pick_idx;
            end
        end else if (winc) begin
            stall_n = '0;
            if (gnt_last) begin
                state_n  = IDLE;
                rr_ptr_n = gnt_id;
            end
        end else if (!wfull) begin
            if (stall_cnt == TW'(IDLE_TO - 1)) begin
                state_n  = IDLE;
                rr_ptr_n = gnt_id;
                abort_n  = 1'b1;
                stall_n  = '0;
            end else begin
                stall_n = stall_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state     <= IDLE;
            gnt_id    <= '0;
            rr_ptr    <= IW'(NREQ - 1);
            stall_cnt <= '0;
            abort_err <= 1'b0;
            wr_count  <= '0;
            wdata_q   <= '0;
        end else begin
            state     <= state_n;
            gnt_id    <= gnt_n;
            rr_ptr    <= rr_ptr_n;
            stall_cnt <= stall_n;
            abort_err <= abort_n;
            if (winc) wr_count <= wr_count + WCNT_W'(1);
            if (busy) wdata_q <= sel_data;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vectors with hand-computed expectations for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    logic        wclk = 1'b0;
    logic        wrst_n;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        wfull, winc, busy, abort_err;
    logic [7:0]  wdata;
    logic [1:0]  gnt_id;
    logic [15:0] wr_count;
    int          checks = 0;
    int          errors = 0;

    fifo_wr_arbiter #(.NREQ(4), .DATASIZE(8), .IDLE_TO(15)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .abort_err (abort_err),
        .wr_count  (wr_count)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge wclk);
        #1;
    endtask

    initial begin
        wrst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; wfull = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt", 32'(gnt_id), 0);
        chk("rst_winc", 32'(winc), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_cnt", 32'(wr_count), 0);
        chk("rst_abort", 32'(abort_err), 0);
        chk("rst_wdata", 32'(wdata), 0);
        tick;
        wrst_n = 1'b1;
        // requesters 0 and 2 contend; 0 wins first after reset
        req_valid = 4'b0101;
        req_data[7:0] = 8'hA0; req_data[23:16] = 8'hC0;
        #1;
        chk("idle_winc", 32'(winc), 0);
        chk("idle_ready", 32'(req_ready), 0);
        tick;
        chk("g0_busy", 32'(busy), 1);
        chk("g0_gnt", 32'(gnt_id), 0);
        chk("g0_winc", 32'(winc), 1);
        chk("g0_ready", 32'(req_ready), 32'b0001);
        chk("g0_wdata", 32'(wdata), 32'hA0);
        tick;
        req_data[7:0] = 8'hA1;
        #1;
        chk("g0_w1", 32'(wdata), 32'hA1);
        tick;
        req_data[7:0] = 8'hA2; req_last = 4'b0001;
        #1;
        chk("g0_w2", 32'(wdata), 32'hA2);
        tick;
        req_last = 4'b0100;
        #1;
        chk("p0_idle", 32'(busy), 0);
        chk("p0_cnt", 32'(wr_count), 3);
        chk("p0_hold", 32'(wdata), 32'hA2);
        chk("p0_winc", 32'(winc), 0);
        tick;
        chk("g2_gnt", 32'(gnt_id), 2);
        chk("g2_wdata", 32'(wdata), 32'hC0);
        tick;
        req_valid = '0; req_last = '0;
        #1;
        chk("g2_cnt", 32'(wr_count), 4);

        // fresh reset, then four single-word streams
        wrst_n = 1'b0;
        tick;
        wrst_n = 1'b1;
        req_valid = 4'b1111; req_last = 4'b1111;
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'h10 + 8'(i);
        for (int c = 0; c < 16; c++) begin
            tick;
            if (c % 2 == 0) begin
                chk("rr_gnt", 32'(gnt_id), 32'((c / 2) % 4));
                chk("rr_winc", 32'(winc), 1);
                chk("rr_wdata", 32'(wdata), 32'h10 + 32'((c / 2) % 4));
            end else begin
                chk("rr_gap", 32'(winc), 0);
            end
        end
        chk("rr_cnt", 32'(wr_count), 8);
        req_valid = '0; req_last = '0;
        tick;

        // requester 1 mid-packet, FIFO full for 20 cycles
        req_valid = 4'b0010; req_data[15:8] = 8'h51;
        tick;
        chk("f_gnt", 32'(gnt_id), 1);
        tick;
        req_data[15:8] = 8'h52; wfull = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("f_winc", 32'(winc), 0);
            tick;
        end
        chk("f_busy", 32'(busy), 1);
        chk("f_abort", 32'(abort_err), 0);
        chk("f_cnt", 32'(wr_count), 9);
        wfull = 1'b0;
        #1;
        chk("f_resume", 32'(winc), 1);
        chk("f_rdy", 32'(req_ready), 32'b0010);
        chk("f_wdata", 32'(wdata), 32'h52);
        tick;
        req_data[15:8] = 8'h53; req_last = 4'b0010;
        #1;
        chk("f_w3", 32'(wdata), 32'h53);
        tick;
        req_valid = '0; req_last = '0;
        #1;
        chk("f_done", 32'(wr_count), 11);
        chk("f_idle", 32'(busy), 0);

        // requester 2 granted then goes silent while 3 waits
        req_valid = 4'b0100;
        tick;
        chk("t_gnt", 32'(gnt_id), 2);
        req_valid = 4'b1000;
        for (int c = 0; c < 14; c++) tick;
        chk("t_pre_busy", 32'(busy), 1);
        chk("t_pre_abort", 32'(abort_err), 0);
        tick;
        chk("t_abort", 32'(abort_err), 1);
        chk("t_busy", 32'(busy), 0);
        tick;
        chk("t_next", 32'(gnt_id), 3);
        chk("t_nbusy", 32'(busy), 1);
        req_data[31:24] = 8'h3C; req_last = 4'b1000;
        tick;
        req_valid = 4'b0001; req_last = '0; req_data[7:0] = 8'h77;
        #1;
        chk("t_cnt", 32'(wr_count), 12);

        // reset pulse in the middle of requester 0's packet
        tick;
        chk("r_gnt", 32'(gnt_id), 0);
        tick;
        chk("r_cnt0", 32'(wr_count), 13);
        req_valid = 4'b1111;
        wrst_n = 1'b0;
        #1;
        chk("r_winc", 32'(winc), 0);
        chk("r_ready", 32'(req_ready), 0);
        chk("r_cnt", 32'(wr_count), 0);
        chk("r_abort", 32'(abort_err), 0);
        tick;
        chk("r_held", 32'(winc), 0);
        wrst_n = 1'b1;
        tick;
        chk("r_first", 32'(gnt_id), 0);
        chk("r_busy", 32'(busy), 1);

        // counter wrap from a preloaded value
        req_valid = 4'b0001;
        force dut.wr_count = 16'hFFFE;
        #1;
        release dut.wr_count;
        #1;
        chk("w_pre", 32'(wr_count), 32'hFFFE);
        tick;
        chk("w_1", 32'(wr_count), 32'hFFFF);
        req_last = 4'b0001;
        tick;
        chk("w_2", 32'(wr_count), 0);
        req_valid = 4'b0001;
        tick;
        tick;
        chk("w_3", 32'(wr_count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters; SHALL be a power of two, 2..8.
REQ-002 Parameter DATASIZE, default 8, write data width in bits.
REQ-003 Parameter IDLE_TO, default 15, maximum stall cycles inside a packet before the grant is revoked.
REQ-004 Clock and reset SHALL be wclk, and wrst_n, which is asynchronous and active-low.
REQ-005 wclk  input  1  write-domain clock; all logic is on its rising edge.
REQ-006 wrst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  NREQ  per-requester valid for the current word.
REQ-008 req_data  input  NREQ*DATASIZE  per-requester data; requester i occupies bits [i*DATASIZE +: DATASIZE].
REQ-009 req_last  input  NREQ  marks the final word of requester i's packet.
REQ-010 req_ready  output  NREQ  word accepted from requester i this cycle when high together with req_valid[i].
REQ-011 wfull  input  1  full flag from the FIFO write side.
REQ-012 winc  output  1  FIFO write strobe.
REQ-013 wdata  output  DATASIZE  FIFO write data.
REQ-014 gnt_id  output  clog2(NREQ)  index of the requester currently holding the grant.
REQ-015 busy  output  1  high while the arbiter is in BUSY.
REQ-016 abort_err  output  1  sticky flag set on a timeout revoke; cleared only by reset.
REQ-017 wr_count  output  16  total accepted words; wraps from 0xFFFF to 0.

Function
REQ-018 The FSM SHALL have two states, IDLE and BUSY, each evaluated on the rising edge of wclk.
REQ-019 In IDLE with any req_valid high, the arbiter SHALL register the winner into gnt_id and enter BUSY on the next edge.
REQ-020 The winner SHALL be the first valid requester searching upward, modulo NREQ, from rr_ptr+1.
REQ-021 In IDLE, req_ready SHALL be all zeros and winc SHALL be 0; arbitration costs exactly 1 cycle.
REQ-022 In BUSY, req_ready[gnt_id] SHALL equal !wfull, and every other req_ready bit SHALL be 0.
REQ-023 In BUSY, winc SHALL equal req_valid[gnt_id] & !wfull, combinationally.
REQ-024 In BUSY, wdata SHALL equal req_data of requester gnt_id, combinationally.
REQ-025 Outside BUSY, wdata SHALL hold its last driven value or zero; its value is don't-care when winc=0.
REQ-026 A transfer with req_last[gnt_id]=1 SHALL set rr_ptr to gnt_id and return the FSM to IDLE on the next edge.
REQ-027 There SHALL be no back-to-back grant without an intervening IDLE cycle.
REQ-028 wfull high SHALL stall the transfer without counting toward the timeout.
REQ-029 The stall counter SHALL increment each BUSY cycle with req_valid[gnt_id]=0 and wfull=0, and clear on any transfer.
REQ-030 When the stall counter reaches IDLE_TO, the arbiter SHALL set abort_err, set rr_ptr to gnt_id, and return to IDLE.
REQ-031 wr_count SHALL increment by 1 on each cycle with winc=1.
REQ-032 A single-word packet (valid and last in the same cycle) SHALL complete in one BUSY cycle.
REQ-033 A requester that drops valid while not granted SHALL not be granted.

Reset
REQ-034 Asserting wrst_n low SHALL immediately force state IDLE, gnt_id 0, rr_ptr NREQ-1 (so requester 0 wins first), stall counter 0, wr_count 0, abort_err 0, and wdata 0.
REQ-035 While in reset, req_ready and winc SHALL be 0.
REQ-036 Reset mid-packet SHALL discard the packet with no further winc.
REQ-037 Reset release SHALL be synchronised externally to wclk.

Structure
REQ-038 The state enum, the gnt_id width function, and the wr_count width constant SHALL live in the shared package fifo_arb_pkg.
REQ-039 The round-robin search SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs onehot winner and its index).

Verification
REQ-040 Reset release with req_valid=4'b0101 -> gnt_id=0 and busy=1 on the second edge; after a 3-word packet from requester 0, the next grant goes to 2.
REQ-041 All four requesters send continuous single-word packets -> grant order 0,1,2,3,0; winc asserted every other cycle; wr_count=8 after 16 cycles.
REQ-042 Requester 1 is mid-packet and wfull is held high for 20 cycles -> winc=0, abort_err stays 0, and the packet resumes intact after wfull drops.
REQ-043 Requester 2 is granted and then holds valid low for 15 cycles -> abort_err=1, busy=0, and requester 3 is granted next.
REQ-044 wrst_n is pulsed low mid-packet -> winc=0 and req_ready=0 immediately; wr_count=0; the first grant after reset goes to requester 0.
REQ-045 wr_count preloaded by forcing it to 0xFFFE, followed by 3 writes -> wr_count=1.
